// File: rtl/io_bram_pkg.sv
// Shared types and widths for the two-requester BRAM port arbiter.
package io_bram_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WE_W   = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // 0 = host loader (r0), 1 = CNN engine (r1)
  typedef logic req_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [WE_W-1:0]   we;
  } bram_beat_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/io_bram_rd_tracker.sv
// Read-return tracker: RD_LAT-deep shift of {valid, id} that follows each
// accepted read until its BRAM data is due.
module io_bram_rd_tracker
  import io_bram_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  req_id_t push_id,
  output logic    out_valid,
  output req_id_t out_id
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: push, id: push_id};
      for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_valid = pipe[RD_LAT-1].valid;
  assign out_id    = pipe[RD_LAT-1].id;

endmodule

// File: rtl/io_bram_arbiter.sv
// Two-requester round-robin arbiter with burst limit in front of one BRAM port.
// Define IO_ARB_ENGINE_PRI_EN to give r1 every idle tie and lift its burst limit.
module io_bram_arbiter
  import io_bram_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              BRAM_PORTA_0_clk,
  input  logic              BRAM_PORTA_0_rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_din,
  input  logic [WE_W-1:0]   r0_we,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_din,
  input  logic [WE_W-1:0]   r1_we,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] BRAM_PORTA_0_addr,
  output logic [DATA_W-1:0] BRAM_PORTA_0_din,
  output logic              BRAM_PORTA_0_en,
  output logic [WE_W-1:0]   BRAM_PORTA_0_we,
  input  logic [DATA_W-1:0] BRAM_PORTA_0_dout
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic clk, rst;
  assign clk = BRAM_PORTA_0_clk;
  assign rst = BRAM_PORTA_0_rst;

  arb_state_e       state, state_nxt;
  req_id_t          last_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             gnt0_c, gnt1_c, accept_c;
  logic             at_limit_c, tie_r1_c, r1_limited_c;
  bram_beat_t       beat_c, beat_q;
  logic             en_q;
  logic             trk_valid;
  req_id_t          trk_id;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign at_limit_c = (burst_cnt >= BURST_MAX);

`ifdef IO_ARB_ENGINE_PRI_EN
  assign tie_r1_c     = 1'b1;
  assign r1_limited_c = 1'b0;
`else
  assign tie_r1_c     = (last_owner == req_id_t'(1'b0));
  assign r1_limited_c = at_limit_c;
`endif

  // Grant decision and next owner
  always_comb begin
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (r0_req && r1_req) begin
          gnt1_c = tie_r1_c;
          gnt0_c = ~tie_r1_c;
        end else begin
          gnt0_c = r0_req;
          gnt1_c = r1_req;
        end
      end
      OWN0: begin
        if (r0_req && !(at_limit_c && r1_req)) gnt0_c = 1'b1;
        else if (r1_req)                       gnt1_c = 1'b1;
      end
      OWN1: begin
        if (r1_req && !(r1_limited_c && r0_req)) gnt1_c = 1'b1;
        else if (r0_req)                         gnt0_c = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end
    if (gnt0_c)      state_nxt = OWN0;
    else if (gnt1_c) state_nxt = OWN1;
  end

  assign r0_gnt   = gnt0_c;
  assign r1_gnt   = gnt1_c;
  assign accept_c = gnt0_c | gnt1_c;
  assign beat_c   = gnt1_c ? '{addr: r1_addr, din: r1_din, we: r1_we}
                           : '{addr: r0_addr, din: r0_din, we: r0_we};

  // Ownership, burst accounting and registered BRAM command
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= req_id_t'(1'b1);
      burst_cnt  <= '0;
      en_q       <= 1'b0;
      beat_q     <= '0;
    end else begin
      state <= state_nxt;
      en_q  <= accept_c;
      if (accept_c) begin
        last_owner <= req_id_t'(gnt1_c);
        beat_q     <= beat_c;
        if (state == IDLE || state_nxt != state) burst_cnt <= CNT_W'(1);
        else if (!at_limit_c)                    burst_cnt <= burst_cnt + CNT_W'(1);
      end else begin
        beat_q.we <= '0;
      end
    end
  end

  assign BRAM_PORTA_0_en   = en_q;
  assign BRAM_PORTA_0_addr = beat_q.addr;
  assign BRAM_PORTA_0_din  = beat_q.din;
  assign BRAM_PORTA_0_we   = beat_q.we;

  io_bram_rd_tracker #(.RD_LAT(RD_LAT)) u_rd_tracker (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_c && (beat_c.we == '0)),
    .push_id   (req_id_t'(gnt1_c)),
    .out_valid (trk_valid),
    .out_id    (trk_id)
  );

  // Read-return routing; rdata shows live BRAM data on the pulse, else holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      r0_rvalid <= trk_valid && (trk_id == req_id_t'(1'b0));
      r1_rvalid <= trk_valid && (trk_id == req_id_t'(1'b1));
      if (r0_rvalid) rdata0_q <= BRAM_PORTA_0_dout;
      if (r1_rvalid) rdata1_q <= BRAM_PORTA_0_dout;
    end
  end

  assign r0_rdata = r0_rvalid ? BRAM_PORTA_0_dout : rdata0_q;
  assign r1_rdata = r1_rvalid ? BRAM_PORTA_0_dout : rdata1_q;

endmodule

// File: tb/tb_io_bram_arbiter.sv
// Scoreboard bench for io_bram_arbiter with a behavioural BRAM of latency RD_LAT.
module tb_io_bram_arbiter;
  import io_bram_pkg::*;

  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned MAX_BURST = 16;
`ifdef IO_ARB_ENGINE_PRI_EN
  localparam bit ENG_PRI = 1'b1;
`else
  localparam bit ENG_PRI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req, r1_req, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] r0_addr, r0_din, r1_addr, r1_din, r0_rdata, r1_rdata;
  logic [3:0]  r0_we, r1_we;
  logic [31:0] bram_addr, bram_din, bram_dout;
  logic        bram_en;
  logic [3:0]  bram_we;

  always #5 clk = ~clk;

  io_bram_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .BRAM_PORTA_0_clk  (clk),
    .BRAM_PORTA_0_rst  (rst),
    .r0_req            (r0_req),
    .r0_addr           (r0_addr),
    .r0_din            (r0_din),
    .r0_we             (r0_we),
    .r0_gnt            (r0_gnt),
    .r0_rvalid         (r0_rvalid),
    .r0_rdata          (r0_rdata),
    .r1_req            (r1_req),
    .r1_addr           (r1_addr),
    .r1_din            (r1_din),
    .r1_we             (r1_we),
    .r1_gnt            (r1_gnt),
    .r1_rvalid         (r1_rvalid),
    .r1_rdata          (r1_rdata),
    .BRAM_PORTA_0_addr (bram_addr),
    .BRAM_PORTA_0_din  (bram_din),
    .BRAM_PORTA_0_en   (bram_en),
    .BRAM_PORTA_0_we   (bram_we),
    .BRAM_PORTA_0_dout (bram_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h01010101) ^ 32'h5A5A0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Behavioural BRAM: read data appears RD_LAT cycles after the enable cycle
  logic [31:0] bram_mem [256];
  logic [31:0] dout_pipe [RD_LAT];
  bit          mem_loaded = 1'b0;
  assign bram_dout = dout_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) bram_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bram_en && bram_we != 4'b0) begin
      bram_mem[bram_addr[9:2]] <= merge(bram_mem[bram_addr[9:2]], bram_din, bram_we);
    end
    dout_pipe[0] <= (bram_en && bram_we == 4'b0) ? bram_mem[bram_addr[9:2]] : 32'h0;
    for (int i = 1; i < int'(RD_LAT); i++) dout_pipe[i] <= dout_pipe[i-1];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    int          at;
  } beat_s;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_s;

  beat_s       rq [2][$];
  rd_s         rdq [2][$];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd [2];
  int          cyc, checks, errors;
  int          m_owner, m_cnt;
  bit          m_last;
  bit          exp_en;
  logic [31:0] exp_addr, exp_din;
  logic [3:0]  exp_we;
  bit          obs_g [2];
  bit          burst_mode, burst_seen_r1, ilv_mode;
  int          burst_r0, ilv_rv;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int r, input logic [31:0] addr, input logic [31:0] din,
                           input logic [3:0] we, input int at);
    beat_s b;
    b.addr = addr; b.din = din; b.we = we; b.at = at;
    rq[r].push_back(b);
  endtask

  // One clock cycle: drive requesters, check DUT at negedge, advance reference model
  task automatic step();
    bit          req [2];
    bit          g [2];
    bit          pick;
    int          gi;
    beat_s       b;
    rd_s         e;
    logic        rv;
    logic [31:0] rd;
    for (int i = 0; i < 2; i++) req[i] = (rq[i].size() > 0) && (rq[i][0].at <= cyc);
    r0_req  = req[0];
    r0_addr = req[0] ? rq[0][0].addr : 32'h0;
    r0_din  = req[0] ? rq[0][0].din  : 32'h0;
    r0_we   = req[0] ? rq[0][0].we   : 4'h0;
    r1_req  = req[1];
    r1_addr = req[1] ? rq[1][0].addr : 32'h0;
    r1_din  = req[1] ? rq[1][0].din  : 32'h0;
    r1_we   = req[1] ? rq[1][0].we   : 4'h0;
    @(negedge clk);

    g[0] = 1'b0; g[1] = 1'b0;
    if (!rst) begin
      if (req[0] && req[1]) begin
        case (m_owner)
          1:       pick = (m_cnt >= int'(MAX_BURST));
          2:       pick = !(!ENG_PRI && m_cnt >= int'(MAX_BURST));
          default: pick = ENG_PRI || !m_last;
        endcase
        g[pick] = 1'b1;
      end else begin
        g[0] = req[0];
        g[1] = req[1];
      end
    end

    obs_g[0] = r0_gnt;
    obs_g[1] = r1_gnt;
    check_eq("r0_gnt", 64'(r0_gnt), 64'(g[0]));
    check_eq("r1_gnt", 64'(r1_gnt), 64'(g[1]));
    check_eq("bram_en", 64'(bram_en), 64'(exp_en));
    check_eq("bram_we", 64'(bram_we), 64'(exp_we));
    if (exp_en) begin
      check_eq("bram_addr", 64'(bram_addr), 64'(exp_addr));
      check_eq("bram_din", 64'(bram_din), 64'(exp_din));
    end
    if (burst_mode && !burst_seen_r1) begin
      if (r1_gnt)      burst_seen_r1 = 1'b1;
      else if (r0_gnt) burst_r0++;
    end

    for (int i = 0; i < 2; i++) begin
      rv = (i == 0) ? r0_rvalid : r1_rvalid;
      rd = (i == 0) ? r0_rdata : r1_rdata;
      if (rv) begin
        if (ilv_mode) ilv_rv++;
        if (rdq[i].size() == 0) begin
          check_eq($sformatf("r%0d_rvalid_unexpected", i), 64'(rv), 64'd0);
        end else begin
          e = rdq[i].pop_front();
          check_eq($sformatf("r%0d_rdata", i), 64'(rd), 64'(e.data));
          check_eq($sformatf("r%0d_rvalid_cycle", i), 64'(cyc), 64'(e.due));
          last_rd[i] = e.data;
        end
      end else begin
        if (rdq[i].size() > 0 && rdq[i][0].due <= cyc) begin
          check_eq($sformatf("r%0d_rvalid_missing", i), 64'(rv), 64'd1);
          e = rdq[i].pop_front();
        end
        check_eq($sformatf("r%0d_rdata_hold", i), 64'(rd), 64'(last_rd[i]));
      end
    end

    if (g[0] || g[1]) begin
      gi = g[1] ? 1 : 0;
      b = rq[gi].pop_front();
      exp_en = 1'b1; exp_addr = b.addr; exp_din = b.din; exp_we = b.we;
      if (b.we == 4'b0) begin
        e.data = ref_mem[b.addr[9:2]];
        e.due  = cyc + 1 + int'(RD_LAT);
        rdq[gi].push_back(e);
      end else begin
        ref_mem[b.addr[9:2]] = merge(ref_mem[b.addr[9:2]], b.din, b.we);
      end
      if (m_owner != gi + 1)            m_cnt = 1;
      else if (m_cnt < int'(MAX_BURST)) m_cnt++;
      m_owner = gi + 1;
      m_last  = (gi == 1);
    end else begin
      exp_en = 1'b0; exp_we = 4'h0; m_owner = 0;
    end

    if (rst) begin
      m_owner = 0; m_last = 1'b1; m_cnt = 0;
      exp_en = 1'b0; exp_we = 4'h0; exp_addr = 32'h0; exp_din = 32'h0;
      rdq[0].delete(); rdq[1].delete();
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size()) != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("drain_beats", 64'(rq[0].size() + rq[1].size()), 64'd0);
    repeat (RD_LAT + 3) step();
    check_eq("rd_outstanding", 64'(rdq[0].size() + rdq[1].size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, t;
    logic [3:0] w;
    r0_req = 1'b0; r0_addr = '0; r0_din = '0; r0_we = '0;
    r1_req = 1'b0; r1_addr = '0; r1_din = '0; r1_we = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    m_owner = 0; m_last = 1'b1; m_cnt = 0;
    exp_en = 1'b0; exp_we = 4'h0; exp_addr = 32'h0; exp_din = 32'h0;
    burst_mode = 1'b0; burst_seen_r1 = 1'b0; burst_r0 = 0;
    ilv_mode = 1'b0; ilv_rv = 0;
    cyc = 0; checks = 0; errors = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, with r0 already requesting a read of 0x10
    push_beat(0, 32'h10, 32'h0, 4'h0, 0);
    repeat (2) step();
    check_eq("rst_addr", 64'(bram_addr), 64'd0);
    check_eq("rst_din", 64'(bram_din), 64'd0);
    check_eq("rst_r0_rvalid", 64'(r0_rvalid), 64'd0);
    check_eq("rst_r1_rvalid", 64'(r1_rvalid), 64'd0);
    rst = 1'b0;
    drain(50);

    // tie straight out of reset
    rst = 1'b1;
    repeat (2) step();
    push_beat(0, 32'h14, 32'h0, 4'h0, cyc);
    push_beat(1, 32'h18, 32'h0, 4'h0, cyc);
    rst = 1'b0;
    step();
    check_eq("tie_winner_r1", 64'(obs_g[1]), 64'(ENG_PRI));
    drain(50);

    // burst limit: r0 streams, r1 joins two cycles later
    base = cyc;
    for (int i = 0; i < 40; i++) push_beat(0, 32'(i * 4), 32'h0, 4'h0, base);
    for (int i = 0; i < 6; i++)  push_beat(1, 32'h100 + 32'(i * 4), 32'h0, 4'h0, base + 2);
    burst_mode = 1'b1;
    drain(200);
    burst_mode = 1'b0;
    check_eq("burst_r0_beats", 64'(burst_r0), 64'(MAX_BURST));

    // alternating reads of words 0..7
    base = cyc;
    for (int k = 0; k < 4; k++) begin
      push_beat(0, 32'(2 * k * 4), 32'h0, 4'h0, base + 2 * k);
      push_beat(1, 32'((2 * k + 1) * 4), 32'h0, 4'h0, base + 2 * k + 1);
    end
    ilv_mode = 1'b1;
    drain(50);
    ilv_mode = 1'b0;
    check_eq("ilv_returns", 64'(ilv_rv), 64'd8);

    // partial and full writes followed by read-back
    base = cyc;
    push_beat(1, 32'h20, 32'hA5A5A5A5, 4'b0011, base);
    push_beat(0, 32'h20, 32'h0, 4'h0, base + 3);
    push_beat(1, 32'h24, 32'h12345678, 4'b1111, base + 4);
    push_beat(1, 32'h24, 32'h0, 4'h0, base + 5);
    drain(50);

    // reset one cycle after a read grant discards the read
    push_beat(0, 32'h30, 32'h0, 4'h0, cyc);
    step();
    check_eq("mid_gnt", 64'(obs_g[0]), 64'd1);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (8) step();

    // random mixed traffic
    base = cyc;
    for (int r = 0; r < 2; r++) begin
      t = base;
      for (int i = 0; i < 50; i++) begin
        t += $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          2:       w = 4'b0011;
          3:       w = 4'b1111;
          default: w = 4'b0000;
        endcase
        push_beat(r, 32'($urandom_range(0, 63)) * 32'd4, $urandom, w, t);
      end
    end
    drain(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
